// File: rtl/sbus_arbiter_pkg.sv
// Shared types for the two-master sbus arbiter: grant/response owner encoding
// and the starvation counter width.
package sbus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } sbus_owner_t;

  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

endpackage

// File: rtl/sbus.sv
// Simple sbus bundle: request fields flow master->slave, data_r/stall flow back.
interface sbus;
  logic        en;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;

  modport master (output en, we, size, addr, data_w, input data_r, stall);
  modport slave  (input en, we, size, addr, data_w, output data_r, stall);
endinterface

// File: rtl/sbus_arb_pick.sv
// Combinational grant selection: a live lock wins outright, otherwise m1 has
// priority unless m0 has been refused for STARVE_LIMIT cycles.
module sbus_arb_pick
  import sbus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_m0_en,
  input  logic                i_m1_en,
  input  logic                i_lock_valid,
  input  sbus_owner_t         i_lock_owner,
  input  logic [STARVE_W-1:0] i_starve_cnt,
  output sbus_owner_t         o_grant
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic w_lock_live;
  logic w_starved;

  // A lock whose owner dropped en is dead; arbitration resumes this cycle.
  assign w_lock_live = i_lock_valid &&
                       (((i_lock_owner == OWN_M0) && i_m0_en) ||
                        ((i_lock_owner == OWN_M1) && i_m1_en));
  assign w_starved   = (i_starve_cnt >= LIMIT);

  always_comb begin
    o_grant = OWN_NONE;
    if (w_lock_live) begin
      o_grant = i_lock_owner;
    end else if (i_m0_en && i_m1_en) begin
      o_grant = w_starved ? OWN_M0 : OWN_M1;
    end else if (i_m0_en) begin
      o_grant = OWN_M0;
    end else if (i_m1_en) begin
      o_grant = OWN_M1;
    end
  end

endmodule

// File: rtl/sbus_arbiter.sv
// Two-master sbus arbiter: fetch (m0) and load/store (m1) share one downstream
// slave; grant is locked across downstream stalls and read data is routed back.
module sbus_arbiter
  import sbus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  sbus.slave   m0,
  sbus.slave   m1,
  sbus.master  down
);

  logic                r_lock_valid;
  sbus_owner_t         r_lock_owner;
  sbus_owner_t         r_resp_owner;
  logic [STARVE_W-1:0] r_starve_cnt;

  sbus_owner_t w_pick;
  sbus_owner_t w_grant;
  logic        w_accept;
  logic        w_m0_accept;

  sbus_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .i_m0_en      (m0.en),
    .i_m1_en      (m1.en),
    .i_lock_valid (r_lock_valid),
    .i_lock_owner (r_lock_owner),
    .i_starve_cnt (r_starve_cnt),
    .o_grant      (w_pick)
  );

  // Reset gates the grant so the address phase is idle while rst is low.
  assign w_grant     = rst ? w_pick : OWN_NONE;
  assign w_accept    = (w_grant != OWN_NONE) && !down.stall;
  assign w_m0_accept = w_accept && (w_grant == OWN_M0);

  always_comb begin
    down.en     = 1'b0;
    down.we     = 1'b0;
    down.size   = 2'b00;
    down.addr   = 32'h0;
    down.data_w = 32'h0;
    case (w_grant)
      OWN_M0: begin
        down.en     = m0.en;
        down.we     = m0.we;
        down.size   = m0.size;
        down.addr   = m0.addr;
        down.data_w = m0.data_w;
      end
      OWN_M1: begin
        down.en     = m1.en;
        down.we     = m1.we;
        down.size   = m1.size;
        down.addr   = m1.addr;
        down.data_w = m1.data_w;
      end
      default: ;
    endcase
  end

  always_comb begin
    m0.stall = 1'b1;
    m1.stall = 1'b1;
    if (rst) begin
      m0.stall = m0.en ? ((w_grant == OWN_M0) ? down.stall : 1'b1) : 1'b0;
      m1.stall = m1.en ? ((w_grant == OWN_M1) ? down.stall : 1'b1) : 1'b0;
    end
  end

  assign m0.data_r = (r_resp_owner == OWN_M0) ? down.data_r : 32'h0;
  assign m1.data_r = (r_resp_owner == OWN_M1) ? down.data_r : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= OWN_NONE;
      r_resp_owner <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_lock_valid <= (w_grant != OWN_NONE) && down.stall;
      r_lock_owner <= ((w_grant != OWN_NONE) && down.stall) ? w_grant : OWN_NONE;
      r_resp_owner <= w_accept ? w_grant : OWN_NONE;
      if (!m0.en || w_m0_accept) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != STARVE_MAX) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sbus_arbiter.sv
// Scoreboard bench for sbus_arbiter: a reference model predicts grant/stall per
// cycle and queues the expected response owner for the following cycle.
module tb_sbus_arbiter;
  import sbus_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic clk;
  logic rst;

  sbus m0_if ();
  sbus m1_if ();
  sbus dn_if ();

  sbus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .rst  (rst),
    .m0   (m0_if),
    .m1   (m1_if),
    .down (dn_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  sbus_owner_t sb_q[$];

  logic        mdl_lock_v;
  sbus_owner_t mdl_lock_o;
  int          mdl_starve;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    m0_if.en = 1'b0; m0_if.we = 1'b0; m0_if.size = 2'b00; m0_if.addr = 32'h0; m0_if.data_w = 32'h0;
    m1_if.en = 1'b0; m1_if.we = 1'b0; m1_if.size = 2'b00; m1_if.addr = 32'h0; m1_if.data_w = 32'h0;
    dn_if.stall = 1'b0;
    dn_if.data_r = 32'h0;
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic step(input logic e0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic e1, input logic w1, input logic [1:0] s1,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic ds, input logic [31:0] dr);
    sbus_owner_t g;
    sbus_owner_t exp_resp;
    logic        acc;
    logic        nxt_lock_v;
    sbus_owner_t nxt_lock_o;
    int          nxt_starve;
    logic [31:0] e_addr, e_dw;
    logic [1:0]  e_size;
    logic        e_we;

    check_eq("starve_cnt", 32'(dut.r_starve_cnt), 32'(mdl_starve));
    check_eq("lock_valid", 32'(dut.r_lock_valid), 32'(mdl_lock_v));
    check_eq("lock_owner", 32'(dut.r_lock_owner), 32'(mdl_lock_o));

    m0_if.en = e0; m0_if.we = w0; m0_if.size = 2'b10; m0_if.addr = a0; m0_if.data_w = d0;
    m1_if.en = e1; m1_if.we = w1; m1_if.size = s1;    m1_if.addr = a1; m1_if.data_w = d1;
    dn_if.stall = ds;
    dn_if.data_r = dr;
    #2;

    if (mdl_lock_v && ((mdl_lock_o == OWN_M0 && e0) || (mdl_lock_o == OWN_M1 && e1)))
      g = mdl_lock_o;
    else if (e0 && e1)
      g = (mdl_starve >= LIMIT) ? OWN_M0 : OWN_M1;
    else if (e0)
      g = OWN_M0;
    else if (e1)
      g = OWN_M1;
    else
      g = OWN_NONE;

    e_we = 1'b0; e_size = 2'b00; e_addr = 32'h0; e_dw = 32'h0;
    if (g == OWN_M0) begin e_we = w0; e_size = 2'b10; e_addr = a0; e_dw = d0; end
    if (g == OWN_M1) begin e_we = w1; e_size = s1;    e_addr = a1; e_dw = d1; end

    check_eq("down_en",     32'(dn_if.en),   32'(g != OWN_NONE));
    check_eq("down_we",     32'(dn_if.we),   32'(e_we));
    check_eq("down_size",   32'(dn_if.size), 32'(e_size));
    check_eq("down_addr",   dn_if.addr,      e_addr);
    check_eq("down_data_w", dn_if.data_w,    e_dw);
    check_eq("m0_stall", 32'(m0_if.stall), 32'(e0 ? ((g == OWN_M0) ? ds : 1'b1) : 1'b0));
    check_eq("m1_stall", 32'(m1_if.stall), 32'(e1 ? ((g == OWN_M1) ? ds : 1'b1) : 1'b0));

    check_eq("sb_depth", sb_q.size(), 32'd1);
    exp_resp = (sb_q.size() != 0) ? sb_q.pop_front() : OWN_NONE;
    check_eq("m0_data_r", m0_if.data_r, (exp_resp == OWN_M0) ? dr : 32'h0);
    check_eq("m1_data_r", m1_if.data_r, (exp_resp == OWN_M1) ? dr : 32'h0);

    acc = (g != OWN_NONE) && !ds;
    sb_q.push_back(acc ? g : OWN_NONE);
    nxt_lock_v = (g != OWN_NONE) && ds;
    nxt_lock_o = nxt_lock_v ? g : OWN_NONE;
    if (!e0 || (acc && g == OWN_M0)) nxt_starve = 0;
    else nxt_starve = (mdl_starve < 15) ? mdl_starve + 1 : 15;

    @(posedge clk);
    #1;
    mdl_lock_v = nxt_lock_v;
    mdl_lock_o = nxt_lock_o;
    mdl_starve = nxt_starve;
  endtask

  // Asserts reset mid-cycle, checks the immediate output response, then
  // releases away from the edge and leaves the bench one unit after an edge.
  task automatic async_reset();
    #1;
    rst = 1'b0;
    #1;
    check_eq("rst_down_en",   32'(dn_if.en),     32'd0);
    check_eq("rst_m0_stall",  32'(m0_if.stall),  32'd1);
    check_eq("rst_m1_stall",  32'(m1_if.stall),  32'd1);
    check_eq("rst_m0_data_r", m0_if.data_r,      32'h0);
    check_eq("rst_m1_data_r", m1_if.data_r,      32'h0);
    check_eq("rst_lock",      32'(dut.r_lock_valid), 32'd0);
    check_eq("rst_resp",      32'(dut.r_resp_owner), 32'(OWN_NONE));
    @(posedge clk);
    #2;
    drive_idle();
    dn_if.data_r = 32'hFFFF_FFFF;
    #2;
    rst = 1'b1;
    mdl_lock_v = 1'b0;
    mdl_lock_o = OWN_NONE;
    mdl_starve = 0;
    sb_q.delete();
    sb_q.push_back(OWN_NONE);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    m0_if.en = 1'b1;
    m1_if.en = 1'b1;
    dn_if.data_r = 32'hFFFF_FFFF;
    async_reset();

    // m1 alone reads 0x100; data arrives the following cycle
    step(0, 0, 32'h0, 32'h0, 1, 0, 2'b10, 32'h100, 32'h0, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 0, 0, 2'b00, 32'h0,   32'h0, 0, 32'hDEAD_BEEF);

    // both requesting: m1 x4, then m0 forced in, then m1 again
    for (int i = 0; i < 6; i++)
      step(1, 0, 32'h200, 32'h0, 1, 0, 2'b10, 32'h300 + 32'(4*i), 32'h0, 0, 32'hA000_0000 + 32'(i));

    // build starvation again, then m0 granted into a 3-cycle downstream stall
    for (int i = 0; i < 3; i++)
      step(1, 0, 32'h240, 32'h0, 1, 0, 2'b10, 32'h340, 32'h0, 0, 32'hB000_0000 + 32'(i));
    for (int i = 0; i < 3; i++)
      step(1, 0, 32'h240, 32'h0, 1, 0, 2'b10, 32'h340, 32'h0, 1, 32'hC000_0000 + 32'(i));
    step(1, 0, 32'h240, 32'h0, 1, 0, 2'b10, 32'h340, 32'h0, 0, 32'hC000_0010);
    step(0, 0, 32'h0,   32'h0, 1, 0, 2'b10, 32'h340, 32'h0, 0, 32'hC000_0020);

    // alternating owners back-to-back
    step(1, 0, 32'h400, 32'h0, 0, 0, 2'b00, 32'h0,   32'h0, 0, 32'h0);
    step(0, 0, 32'h0,   32'h0, 1, 0, 2'b10, 32'h500, 32'h0, 0, 32'h1111_1111);
    step(0, 0, 32'h0,   32'h0, 0, 0, 2'b00, 32'h0,   32'h0, 0, 32'h2222_2222);

    // lock m1, then reset mid-lock
    step(0, 0, 32'h0, 32'h0, 1, 0, 2'b01, 32'h600, 32'h0, 1, 32'h0);
    check_eq("pre_rst_lock", 32'(dut.r_lock_valid), 32'd1);
    async_reset();
    step(1, 0, 32'h700, 32'h0, 1, 0, 2'b10, 32'h800, 32'h0, 0, 32'h5555_5555);
    step(0, 0, 32'h0,   32'h0, 0, 0, 2'b00, 32'h0,   32'h0, 0, 32'h6666_6666);

    // m1 write
    step(0, 0, 32'h0, 32'h0, 1, 1, 2'b10, 32'h900, 32'h1234_5678, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 0, 0, 2'b00, 32'h0,   32'h0,         0, 32'hCAFE_F00D);

    // random traffic
    for (int i = 0; i < 80; i++)
      step(1'($urandom), 1'($urandom), $urandom, $urandom,
           1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
           ($urandom_range(0, 3) == 0), $urandom);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sbus_arbiter.md
# sbus_arbiter

Two-master arbiter that shares a single sbus slave (typically the SRAM bridge) between the instruction-fetch port (m0) and the load/store port (m1). The data port has fixed priority; a starvation counter forces a grant to fetch after a bounded wait. The arbiter locks the grant across downstream stalls and routes the one-cycle-late read data back to the master that issued the request. It sits between the core's two memory ports and the on-chip SRAM bridge.

## Interface
- STARVE_LIMIT, default 4: consecutive cycles m0 may be refused while requesting before it wins priority (1..15).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0); clears all state immediately.
- m0  sbus.slave  -  instruction-fetch master (en, we, size[1:0], addr, data_w, data_r, stall).
- m1  sbus.slave  -  load/store master, same fields.
- down  sbus.master  -  shared downstream slave; returns data_r one cycle after an accepted request and may assert stall.

## Operation
- Request: mX.en=1. Acceptance: the granted request is driven onto down with down.stall=0.
- Grant selection, evaluated when unlocked:
  - only one requester: that master wins;
  - both requesting: m1 wins unless starve_cnt ≥ STARVE_LIMIT, in which case m0 wins.
- Address phase is a combinational mux. down.en/we/size/addr/data_w come from the granted master. With no grant, down.en=0, down.we=0 and the other fields are 0.
- Stall outputs:
  - a requesting master that is not granted sees stall=1;
  - the granted master sees down.stall;
  - a master with en=0 sees stall=0.
- Lock: if the granted request sees down.stall=1, register lock_valid=1 and lock_owner=granted. While lock_valid=1, the grant stays with lock_owner regardless of priority. The lock clears on the first cycle the request is accepted.
- If the locked owner drops en during a lock (protocol violation), the lock clears and arbitration resumes in the same cycle.
- Response routing: on acceptance, register resp_owner ∈ {OWN_M0, OWN_M1}. Otherwise register OWN_NONE.
  - The next cycle, resp_owner receives down.data_r.
  - The other master receives 32'h0.
  - With OWN_NONE, both masters receive 0.
- Starvation counter starve_cnt, 4 bits, saturating at 15:
  - increments when m0.en=1 and m0 is not accepted;
  - clears when m0 is accepted or m0.en=0.
- Back-to-back accepted requests are allowed every cycle, with no bubble between owners.

## Timing
- Reset (rst=0) values:
  - lock_valid=0, lock_owner=OWN_NONE, resp_owner=OWN_NONE, starve_cnt=0;
  - combinational outputs while in reset: down.en=0, m0.stall=m1.stall=1, m0.data_r=m1.data_r=0.
- Request-to-acceptance: 0 cycles when granted and down.stall=0.
- Read data appears at the master exactly 1 cycle after acceptance, aligned to down.data_r.
- Reset asserted mid-lock or mid-response drops the pending response. After release, the first cycle arbitrates fresh.
- The grant decision uses the registered starve_cnt, never the current-cycle update, so there is no combinational loop through stall.
- All paths from mX.en to down.en and mX.stall are purely combinational, with no register stage.

## Structure
- Package includes gains `typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} sbus_owner_t` and `localparam int STARVE_W = 4`.
- One sub-module, sbus_arb_pick. It is combinational: inputs m0.en, m1.en, lock_valid, lock_owner and starve_cnt; output is the grant as sbus_owner_t.
- Top level holds the registers (lock, resp_owner, starve_cnt) and the muxes.

## Test plan
- **m1 only:** m1 reads addr 32'h100, down.data_r=32'hDEADBEEF next cycle.
  - m1.stall=0, and m1.data_r=32'hDEADBEEF one cycle later.
  - m0.data_r=0.
- **Both request, STARVE_LIMIT=4, m1 continuously busy:**
  - m1 is accepted for 4 cycles and m0.stall=1 throughout;
  - cycle 5: m0 is granted, m1.stall=1;
  - starve_cnt=0 after m0's acceptance.
- **Downstream stall under lock:** m0 granted, down.stall=1 for 3 cycles while m1 also requests.
  - down.addr stays m0's address for all 3 cycles.
  - m0.stall=1 and m1.stall=1 during the stall.
  - m0 is accepted on cycle 4; m1 is granted on cycle 5.
- **Alternating owners back-to-back:** m0 read at cycle t, m1 read at t+1.
  - m0.data_r valid at t+1 and m1.data_r valid at t+2, each with the other port at 0.
- **Reset mid-lock:** assert rst=0 asynchronously while lock_valid=1.
  - down.en=0 immediately.
  - After release, m1 wins a simultaneous request and no stale data_r is delivered.
- **Write:** m1 write, size=2'b10, data_w=32'h12345678.
  - down.we=1 and down.data_w=32'h12345678 in the same cycle.
  - resp_owner=OWN_M1 next cycle, data ignored by the master.
